// File: rtl/leaf_max_arbiter_if.sv
// Purpose: bundles the trav write ports, leaf read port and leaf_max BRAM ports of leaf_max_arbiter.
// Latency: none (wiring only).
// Backpressure: trav*_stall flows master-ward; the read port is never stalled.
// Optional macro LEAF_MAX_ARB_STATS_EN adds the stall_cnt0/stall_cnt1/fwd_cnt statistics outputs.
// slave modport = arbiter side, master modport = requesters plus BRAM side.
interface leaf_max_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // trav0 / trav1 write requests
    logic              trav0_valid;
    logic [ADDR_W-1:0] trav0_rayID;
    logic [DATA_W-1:0] trav0_t_max;
    logic              trav0_stall;
    logic              trav1_valid;
    logic [ADDR_W-1:0] trav1_rayID;
    logic [DATA_W-1:0] trav1_t_max;
    logic              trav1_stall;
    // leaf read request and result
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_rayID;
    logic              rd_out_valid;
    logic [ADDR_W-1:0] rd_out_rayID;
    logic [DATA_W-1:0] rd_out_t_max;
    // leaf_max BRAM ports
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wrdata_a;
    logic              wren_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wrdata_b;
    logic              wren_b;
    logic [DATA_W-1:0] q_a;
`ifdef LEAF_MAX_ARB_STATS_EN
    logic [15:0]       stall_cnt0;
    logic [15:0]       stall_cnt1;
    logic [15:0]       fwd_cnt;
`endif

    modport slave (
        input  trav0_valid, trav0_rayID, trav0_t_max,
        output trav0_stall,
        input  trav1_valid, trav1_rayID, trav1_t_max,
        output trav1_stall,
        input  rd_valid, rd_rayID,
        output rd_out_valid, rd_out_rayID, rd_out_t_max,
        output addr_a, wrdata_a, wren_a,
        output addr_b, wrdata_b, wren_b,
        input  q_a
`ifdef LEAF_MAX_ARB_STATS_EN
        ,
        output stall_cnt0, stall_cnt1, fwd_cnt
`endif
    );

    modport master (
        output trav0_valid, trav0_rayID, trav0_t_max,
        input  trav0_stall,
        output trav1_valid, trav1_rayID, trav1_t_max,
        input  trav1_stall,
        output rd_valid, rd_rayID,
        input  rd_out_valid, rd_out_rayID, rd_out_t_max,
        input  addr_a, wrdata_a, wren_a,
        input  addr_b, wrdata_b, wren_b,
        output q_a
`ifdef LEAF_MAX_ARB_STATS_EN
        ,
        input  stall_cnt0, stall_cnt1, fwd_cnt
`endif
    );
endinterface

// File: rtl/leaf_max_arbiter.sv
// Purpose: shares both ports of the 512x32 leaf_max BRAM between leaf reads and two trav write streams.
// Latency: reads return exactly 2 cycles after request; writes are issued in the grant cycle.
// Backpressure: reads never stall; a contending trav write stalls at most 1 cycle (round robin).
// Ports: clk, rst (async active-high); arb (leaf_max_arbiter_if.slave) carries the trav0/trav1
//   write requests and stalls, the leaf read request/result and BRAM ports A/B.
// Optional macro LEAF_MAX_ARB_STATS_EN adds saturating stall_cnt0/stall_cnt1/fwd_cnt counters.
module leaf_max_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    leaf_max_arbiter_if.slave    arb
);
    logic              rr;          // preferred requester on contention (0 = trav0)
    logic              rr_next;
    logic              both;
    logic              same_ray;
    logic              contended;
    logic              win1;        // trav1 is the port-B winner this cycle
    logic              fwd_hit;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wrdata_a;
    logic              wren_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wrdata_b;
    logic              wren_b;
    logic              stall0;
    logic              stall1;

    // read pipeline: s1 = cycle in which q_a is valid, out = registered result
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_ray;
    logic              s1_fwd;
    logic [DATA_W-1:0] s1_fwd_dat;
    logic              out_vld;
    logic [ADDR_W-1:0] out_ray;
    logic [DATA_W-1:0] out_t_max;

    always_comb begin
        addr_a    = '0;
        wrdata_a  = '0;
        wren_a    = 1'b0;
        addr_b    = '0;
        wrdata_b  = '0;
        wren_b    = 1'b0;
        both      = arb.trav0_valid & arb.trav1_valid;
        same_ray  = both && (arb.trav0_rayID == arb.trav1_rayID);
        // with a read, port B is the only write port, so any double request contends;
        // without one, only an address clash does (two ports writing one word is undefined)
        contended = arb.rd_valid ? both : same_ray;
        win1      = both ? rr : arb.trav1_valid;

        if (arb.rd_valid || same_ray) begin
            addr_a = arb.rd_valid ? arb.rd_rayID : '0;
            if (arb.trav0_valid || arb.trav1_valid) begin
                wren_b   = 1'b1;
                addr_b   = win1 ? arb.trav1_rayID : arb.trav0_rayID;
                wrdata_b = win1 ? arb.trav1_t_max : arb.trav0_t_max;
            end
        end else begin
            if (arb.trav0_valid) begin
                wren_a   = 1'b1;
                addr_a   = arb.trav0_rayID;
                wrdata_a = arb.trav0_t_max;
            end
            if (arb.trav1_valid) begin
                wren_b   = 1'b1;
                addr_b   = arb.trav1_rayID;
                wrdata_b = arb.trav1_t_max;
            end
        end

        stall0  = contended & win1;
        stall1  = contended & ~win1;
        // pointer moves to the loser so it wins next time
        rr_next = contended ? ~win1 : rr;
        // BRAM returns old data on a same-address port-B write, so capture the new value
        fwd_hit = arb.rd_valid & wren_b & (addr_b == arb.rd_rayID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr         <= 1'b0;
            s1_vld     <= 1'b0;
            s1_ray     <= '0;
            s1_fwd     <= 1'b0;
            s1_fwd_dat <= '0;
            out_vld    <= 1'b0;
            out_ray    <= '0;
            out_t_max  <= '0;
        end else begin
            rr         <= rr_next;
            s1_vld     <= arb.rd_valid;
            s1_ray     <= arb.rd_rayID;
            s1_fwd     <= fwd_hit;
            s1_fwd_dat <= wrdata_b;
            out_vld    <= s1_vld;
            out_ray    <= s1_vld ? s1_ray : '0;
            if (!s1_vld)
                out_t_max <= '0;
            else if (s1_fwd)
                out_t_max <= s1_fwd_dat;
            else
                out_t_max <= arb.q_a;
        end
    end

    assign arb.addr_a       = addr_a;
    assign arb.wrdata_a     = wrdata_a;
    assign arb.wren_a       = wren_a;
    assign arb.addr_b       = addr_b;
    assign arb.wrdata_b     = wrdata_b;
    assign arb.wren_b       = wren_b;
    assign arb.trav0_stall  = stall0;
    assign arb.trav1_stall  = stall1;
    assign arb.rd_out_valid = out_vld;
    assign arb.rd_out_rayID = out_ray;
    assign arb.rd_out_t_max = out_t_max;

`ifdef LEAF_MAX_ARB_STATS_EN
    logic [15:0] stall_cnt0;
    logic [15:0] stall_cnt1;
    logic [15:0] fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
            fwd_cnt    <= '0;
        end else begin
            if (arb.trav0_valid && stall0 && stall_cnt0 != 16'hFFFF)
                stall_cnt0 <= stall_cnt0 + 16'd1;
            if (arb.trav1_valid && stall1 && stall_cnt1 != 16'hFFFF)
                stall_cnt1 <= stall_cnt1 + 16'd1;
            if (fwd_hit && fwd_cnt != 16'hFFFF)
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end

    assign arb.stall_cnt0 = stall_cnt0;
    assign arb.stall_cnt1 = stall_cnt1;
    assign arb.fwd_cnt    = fwd_cnt;
`endif
endmodule

// File: tb/tb_leaf_max_arbiter.sv
// Purpose: directed self-checking bench for leaf_max_arbiter with a behavioural 512x32 BRAM.
// Latency: checks the 2-cycle read path and same-cycle write grants.
// Backpressure: checks round-robin stalls and same-rayID arbitration.
module tb_leaf_max_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    leaf_max_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) arb ();

    leaf_max_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    // BRAM: registered address, old data on read-during-write
    logic [DATA_W-1:0] mem [0:511];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        arb.q_a = '0;
    end
    always @(posedge clk) begin
        if (arb.wren_a) mem[arb.addr_a] <= arb.wrdata_a;
        if (arb.wren_b) mem[arb.addr_b] <= arb.wrdata_b;
        arb.q_a <= mem[arb.addr_a];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        arb.trav0_valid = 1'b0; arb.trav0_rayID = '0; arb.trav0_t_max = '0;
        arb.trav1_valid = 1'b0; arb.trav1_rayID = '0; arb.trav1_t_max = '0;
        arb.rd_valid    = 1'b0; arb.rd_rayID    = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        #1;
        checks++; if (arb.rd_out_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_out_valid got %b want 0", arb.rd_out_valid); end
        checks++; if (arb.rd_out_rayID !== '0) begin errors++; $display("FAIL reset_rd_out_rayID got %h want 0", arb.rd_out_rayID); end
        checks++; if (arb.rd_out_t_max !== '0) begin errors++; $display("FAIL reset_rd_out_t_max got %h want 0", arb.rd_out_t_max); end
        checks++; if ({arb.wren_a, arb.wren_b} !== 2'b00) begin errors++; $display("FAIL reset_wren got %b want 00", {arb.wren_a, arb.wren_b}); end
        checks++; if ({arb.trav0_stall, arb.trav1_stall} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b want 00", {arb.trav0_stall, arb.trav1_stall}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_parallel_writes();
        arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd5; arb.trav0_t_max = 32'h40A00000;
        arb.trav1_valid = 1'b1; arb.trav1_rayID = 9'd7; arb.trav1_t_max = 32'h41000000;
        #1;
        checks++; if ({arb.wren_a, arb.wren_b} !== 2'b11) begin errors++; $display("FAIL par_wren got %b want 11", {arb.wren_a, arb.wren_b}); end
        checks++; if ({arb.addr_a, arb.wrdata_a} !== {9'd5, 32'h40A00000}) begin errors++; $display("FAIL par_port_a got %h/%h want 5/40a00000", arb.addr_a, arb.wrdata_a); end
        checks++; if ({arb.addr_b, arb.wrdata_b} !== {9'd7, 32'h41000000}) begin errors++; $display("FAIL par_port_b got %h/%h want 7/41000000", arb.addr_b, arb.wrdata_b); end
        checks++; if ({arb.trav0_stall, arb.trav1_stall} !== 2'b00) begin errors++; $display("FAIL par_stall got %b want 00", {arb.trav0_stall, arb.trav1_stall}); end
        step(); idle(); step();
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd7;
        #1;
        checks++; if ({arb.wren_a, arb.addr_a} !== {1'b0, 9'd7}) begin errors++; $display("FAIL par_read_port_a got %b/%h want 0/7", arb.wren_a, arb.addr_a); end
        step(); idle();
        checks++; if (arb.rd_out_valid !== 1'b0) begin errors++; $display("FAIL par_read_early got %b want 0", arb.rd_out_valid); end
        step();
        checks++; if ({arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max} !== {1'b1, 9'd7, 32'h41000000})
            begin errors++; $display("FAIL par_read_result got %b/%h/%h want 1/7/41000000", arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] rays [6];
        logic [DATA_W-1:0] vals [6];
        logic              gnt  [6];
        int s0 = 0;
        int s1 = 0;
        rays = '{9'd5, 9'd7, 9'd5, 9'd7, 9'd5, 9'd7};
        vals = '{32'h40A00000, 32'h41000000, 32'h40A00000, 32'h41000000, 32'h40A00000, 32'h41000000};
        gnt  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                arb.rd_valid = 1'b1; arb.rd_rayID = rays[i];
                arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd20; arb.trav0_t_max = 32'hA0A0A0A0;
                arb.trav1_valid = 1'b1; arb.trav1_rayID = 9'd21; arb.trav1_t_max = 32'hB1B1B1B1;
                #1;
                if (arb.trav0_stall) s0++;
                if (arb.trav1_stall) s1++;
                checks++; if ({arb.wren_a, arb.addr_a} !== {1'b0, rays[i]}) begin errors++; $display("FAIL b2b_port_a[%0d] got %b/%h want 0/%h", i, arb.wren_a, arb.addr_a, rays[i]); end
                checks++; if ({arb.wren_b, arb.addr_b, arb.trav0_stall, arb.trav1_stall} !== {1'b1, (gnt[i] ? 9'd21 : 9'd20), gnt[i], ~gnt[i]})
                    begin errors++; $display("FAIL b2b_grant[%0d] got wren_b=%b addr_b=%h stalls=%b%b want grant trav%0d", i, arb.wren_b, arb.addr_b, arb.trav0_stall, arb.trav1_stall, gnt[i]); end
            end else begin
                idle();
            end
            if (i >= 2 && i < 8) begin
                checks++; if ({arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max} !== {1'b1, rays[i-2], vals[i-2]})
                    begin errors++; $display("FAIL b2b_result[%0d] got %b/%h/%h want 1/%h/%h", i-2, arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max, rays[i-2], vals[i-2]); end
            end else begin
                checks++; if (arb.rd_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_result[%0d] got %b want 0", i, arb.rd_out_valid); end
            end
            step();
        end
        checks++; if (s0 != 3 || s1 != 3) begin errors++; $display("FAIL b2b_stall_counts got %0d/%0d want 3/3", s0, s1); end
`ifdef LEAF_MAX_ARB_STATS_EN
        checks++; if ({arb.stall_cnt0, arb.stall_cnt1} !== {16'd3, 16'd3}) begin errors++; $display("FAIL stats_stall got %0d/%0d want 3/3", arb.stall_cnt0, arb.stall_cnt1); end
`endif
    endtask

    task automatic test_forwarding();
        // preload old value through port A
        arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd12; arb.trav0_t_max = 32'h3F800000;
        step(); idle();
        // read and trav1 write of the same rayID in one cycle
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd12;
        arb.trav1_valid = 1'b1; arb.trav1_rayID = 9'd12; arb.trav1_t_max = 32'h40400000;
        #1;
        checks++; if ({arb.wren_a, arb.wren_b, arb.addr_b, arb.trav1_stall} !== {1'b0, 1'b1, 9'd12, 1'b0})
            begin errors++; $display("FAIL fwd_grant got wren=%b%b addr_b=%h stall1=%b want 01/00c/0", arb.wren_a, arb.wren_b, arb.addr_b, arb.trav1_stall); end
        step(); idle(); step();
        checks++; if ({arb.rd_out_valid, arb.rd_out_t_max} !== {1'b1, 32'h40400000}) begin errors++; $display("FAIL fwd_result got %b/%h want 1/40400000", arb.rd_out_valid, arb.rd_out_t_max); end
        // plain re-read, then a write landing one cycle after the read is not forwarded
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd12;
        step(); idle();
        arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd12; arb.trav0_t_max = 32'h40800000;
        step(); idle();
        checks++; if ({arb.rd_out_valid, arb.rd_out_t_max} !== {1'b1, 32'h40400000}) begin errors++; $display("FAIL fwd_reread got %b/%h want 1/40400000", arb.rd_out_valid, arb.rd_out_t_max); end
`ifdef LEAF_MAX_ARB_STATS_EN
        checks++; if (arb.fwd_cnt !== 16'd1) begin errors++; $display("FAIL stats_fwd got %0d want 1", arb.fwd_cnt); end
`endif
        step();
    endtask

    task automatic test_same_ray();
        arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd3; arb.trav0_t_max = 32'h11111111;
        arb.trav1_valid = 1'b1; arb.trav1_rayID = 9'd3; arb.trav1_t_max = 32'h22222222;
        #1;
        checks++; if ({arb.wren_a, arb.wren_b, arb.addr_b, arb.wrdata_b} !== {1'b0, 1'b1, 9'd3, 32'h11111111})
            begin errors++; $display("FAIL same_first got wren=%b%b addr_b=%h data=%h want 01/003/11111111", arb.wren_a, arb.wren_b, arb.addr_b, arb.wrdata_b); end
        checks++; if ({arb.trav0_stall, arb.trav1_stall} !== 2'b01) begin errors++; $display("FAIL same_first_stall got %b want 01", {arb.trav0_stall, arb.trav1_stall}); end
        step();
        arb.trav0_valid = 1'b0;
        #1;
        checks++; if ({arb.wren_a, arb.wren_b, arb.wrdata_b, arb.trav1_stall} !== {1'b0, 1'b1, 32'h22222222, 1'b0})
            begin errors++; $display("FAIL same_second got wren=%b%b data=%h stall1=%b want 01/22222222/0", arb.wren_a, arb.wren_b, arb.wrdata_b, arb.trav1_stall); end
        step(); idle();
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd3;
        step(); idle(); step();
        checks++; if ({arb.rd_out_valid, arb.rd_out_t_max} !== {1'b1, 32'h22222222}) begin errors++; $display("FAIL same_readback got %b/%h want 1/22222222", arb.rd_out_valid, arb.rd_out_t_max); end
        step();
    endtask

    task automatic test_reset_midflight();
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd5;
        step();
        arb.rd_rayID = 9'd7;
        step(); idle();
        #1;
        checks++; if (arb.rd_out_valid !== 1'b1) begin errors++; $display("FAIL mid_before_rst got %b want 1", arb.rd_out_valid); end
        rst = 1'b1;
        #1;
        checks++; if ({arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max} !== {1'b0, 9'd0, 32'd0})
            begin errors++; $display("FAIL mid_rst_async got %b/%h/%h want 0/0/0", arb.rd_out_valid, arb.rd_out_rayID, arb.rd_out_t_max); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (arb.rd_out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_rst[%0d] got %b want 0", i, arb.rd_out_valid); end
        end
        arb.rd_valid = 1'b1; arb.rd_rayID = 9'd42;
        arb.trav0_valid = 1'b1; arb.trav0_rayID = 9'd40; arb.trav0_t_max = 32'h1;
        arb.trav1_valid = 1'b1; arb.trav1_rayID = 9'd41; arb.trav1_t_max = 32'h2;
        #1;
        checks++; if ({arb.addr_b, arb.trav0_stall, arb.trav1_stall} !== {9'd40, 2'b01})
            begin errors++; $display("FAIL mid_rr_reset got addr_b=%h stalls=%b%b want 028/01", arb.addr_b, arb.trav0_stall, arb.trav1_stall); end
        step(); idle(); step(); step();
    endtask

    initial begin
        test_reset();
        test_parallel_writes();
        test_back_to_back();
        test_forwarding();
        test_same_ray();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
